// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the demux select sequencer.
// Optional GAP state is used only when SEQ_GAP_EN is defined.
package demux_seq_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        GAP
    } state_t;

    // Cyclic search for the next set mask bit after cur; returns cur if none other is set.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] cur,
                                                 input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] idx;
        next_ch = cur;
        for (int i = NUM_CH - 1; i >= 1; i--) begin
            idx = cur + i[SEL_W-1:0];
            if (mask[idx]) next_ch = idx;
        end
    endfunction

endpackage

// File: rtl/demux_sel_sequencer_rr_next_ch.sv
// Round-robin next-channel finder; wrap flags that cur was the highest enabled channel.
module rr_next_ch
    import demux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next_idx,
    output logic              wrap
);

    assign next_idx = next_ch(cur, mask);
    // No enabled channel above cur means the search wrapped (or reselected cur).
    assign wrap     = (next_idx <= cur);

endmodule

// File: rtl/demux_sel_sequencer.sv
// Round-robin s0/s1 select generator with per-channel dwell for a 1x4 demux decoder.
// Define SEQ_GAP_EN to insert a break-before-make GAP cycle between dwells.
module demux_sel_sequencer
    import demux_seq_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               s0,
    output logic               s1,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state, state_n;
    logic [SEL_W-1:0]   ch, ch_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] dwell_r, dwell_n;
    logic [NUM_CH-1:0]  en_r, en_n;
    logic               stop_pend, stop_pend_n;
    logic               sel_valid_n, busy_n, frame_done_n;
    logic [SEL_W-1:0]   next_idx;
    logic               wrap;

    rr_next_ch u_next (
        .mask     (en_r),
        .cur      (ch),
        .next_idx (next_idx),
        .wrap     (wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            cnt        <= '0;
            dwell_r    <= '0;
            en_r       <= '0;
            stop_pend  <= 1'b0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            ch         <= ch_n;
            cnt        <= cnt_n;
            dwell_r    <= dwell_n;
            en_r       <= en_n;
            stop_pend  <= stop_pend_n;
            sel_valid  <= sel_valid_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        ch_n         = ch;
        cnt_n        = cnt;
        dwell_n      = dwell_r;
        en_n         = en_r;
        stop_pend_n  = stop_pend;
        sel_valid_n  = sel_valid;
        busy_n       = busy;
        frame_done_n = 1'b0;
        case (state)
            IDLE: begin
                if (start && (ch_en != '0)) begin
                    en_n        = ch_en;
                    dwell_n     = (dwell == '0) ? ONE : dwell;
                    ch_n        = next_ch(SEL_W'(NUM_CH - 1), ch_en);
                    cnt_n       = ONE;
                    stop_pend_n = 1'b0;
                    sel_valid_n = 1'b1;
                    busy_n      = 1'b1;
                    state_n     = DWELL;
                end
            end
            DWELL: begin
                if (stop) stop_pend_n = 1'b1;
                if (cnt == dwell_r) begin
                    frame_done_n = wrap;
                    cnt_n        = ONE;
                    if (wrap && stop_pend) begin
                        state_n     = IDLE;
                        ch_n        = '0;
                        sel_valid_n = 1'b0;
                        busy_n      = 1'b0;
                        stop_pend_n = 1'b0;
                    end else begin
`ifdef SEQ_GAP_EN
                        state_n     = GAP;
                        sel_valid_n = 1'b0;
`else
                        ch_n        = next_idx;
`endif
                    end
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
`ifdef SEQ_GAP_EN
            GAP: begin
                // s0/s1 held on the outgoing channel during GAP; switch on exit.
                if (stop) stop_pend_n = 1'b1;
                state_n     = DWELL;
                ch_n        = next_idx;
                sel_valid_n = 1'b1;
            end
`endif
            default: begin
                state_n     = IDLE;
                ch_n        = '0;
                sel_valid_n = 1'b0;
                busy_n      = 1'b0;
            end
        endcase
    end

    assign s0 = ch[1];
    assign s1 = ch[0];

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Directed self-checking bench for demux_sel_sequencer.
// Observed vector per check is {s0,s1,sel_valid,busy,frame_done}.
module tb_demux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] ch_en;
    logic [3:0] dwell;
    logic       s0, s1, sel_valid, busy, frame_done;

    int vectors = 0;
    int miscompares = 0;

    demux_sel_sequencer #(.DWELL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .ch_en      (ch_en),
        .dwell      (dwell),
        .s0         (s0),
        .s1         (s1),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start(input logic [3:0] en, input logic [3:0] dw);
        ch_en = en;
        dwell = dw;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; ch_en = 4'b0; dwell = 4'd0;
        #2;
        vectors++;
        if ({s0, s1, sel_valid, busy, frame_done} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset got=%b exp=%b", {s0, s1, sel_valid, busy, frame_done}, 5'b00000);
        end
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({s0, s1, sel_valid, busy, frame_done} !== 5'b00000) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%b exp=%b", {s0, s1, sel_valid, busy, frame_done}, 5'b00000);
        end
    endtask

    task automatic test_all_ch();
        logic [4:0] exp;
        pulse_start(4'b1111, 4'd2);
        for (int k = 0; k < 18; k++) begin
            exp = {2'((k / 2) % 4), 1'b1, 1'b1, (k > 0) && (k % 8 == 0)};
            vectors++;
            if ({s0, s1, sel_valid, busy, frame_done} !== exp) begin
                miscompares++;
                $display("FAIL all_ch k=%0d got=%b exp=%b", k, {s0, s1, sel_valid, busy, frame_done}, exp);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_sparse();
        logic [4:0] exp;
        pulse_start(4'b1010, 4'd3);
        // New mask/dwell while busy must not take effect.
        ch_en = 4'b1111;
        dwell = 4'd1;
        for (int k = 0; k < 13; k++) begin
            exp = {(((k / 3) % 2) == 1) ? 2'b11 : 2'b01, 1'b1, 1'b1, (k > 0) && (k % 6 == 0)};
            vectors++;
            if ({s0, s1, sel_valid, busy, frame_done} !== exp) begin
                miscompares++;
                $display("FAIL sparse k=%0d got=%b exp=%b", k, {s0, s1, sel_valid, busy, frame_done}, exp);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_dwell_zero();
        logic [4:0] exp;
        pulse_start(4'b0100, 4'd0);
        for (int k = 0; k < 6; k++) begin
            exp = {2'b10, 1'b1, 1'b1, k > 0};
            vectors++;
            if ({s0, s1, sel_valid, busy, frame_done} !== exp) begin
                miscompares++;
                $display("FAIL dwell_zero k=%0d got=%b exp=%b", k, {s0, s1, sel_valid, busy, frame_done}, exp);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_stop();
        logic [4:0] exp;
        pulse_start(4'b1111, 4'd2);
        for (int k = 0; k < 11; k++) begin
            if (k < 8)       exp = {2'(k / 2), 1'b1, 1'b1, 1'b0};
            else if (k == 8) exp = 5'b00001;
            else             exp = 5'b00000;
            vectors++;
            if ({s0, s1, sel_valid, busy, frame_done} !== exp) begin
                miscompares++;
                $display("FAIL stop k=%0d got=%b exp=%b", k, {s0, s1, sel_valid, busy, frame_done}, exp);
            end
            stop = (k == 2);
            tick();
            stop = 1'b0;
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        pulse_start(4'b1111, 4'd4);
        for (int k = 0; k < 9; k++) tick();
        vectors++;
        if ({s0, s1, sel_valid, busy, frame_done} !== 5'b10110) begin
            miscompares++;
            $display("FAIL pre_async_reset got=%b exp=%b", {s0, s1, sel_valid, busy, frame_done}, 5'b10110);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({s0, s1, sel_valid, busy, frame_done} !== 5'b00000) begin
            miscompares++;
            $display("FAIL async_reset got=%b exp=%b", {s0, s1, sel_valid, busy, frame_done}, 5'b00000);
        end
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({s0, s1, sel_valid, busy, frame_done} !== 5'b00000) begin
            miscompares++;
            $display("FAIL after_async_reset got=%b exp=%b", {s0, s1, sel_valid, busy, frame_done}, 5'b00000);
        end
        pulse_start(4'b1111, 4'd1);
        vectors++;
        if ({s0, s1, sel_valid, busy, frame_done} !== 5'b00110) begin
            miscompares++;
            $display("FAIL restart_ch0 got=%b exp=%b", {s0, s1, sel_valid, busy, frame_done}, 5'b00110);
        end
        do_reset();
    endtask

    task automatic test_empty_start();
        pulse_start(4'b0000, 4'd2);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({s0, s1, sel_valid, busy, frame_done} !== 5'b00000) begin
                miscompares++;
                $display("FAIL empty_start k=%0d got=%b exp=%b", k, {s0, s1, sel_valid, busy, frame_done}, 5'b00000);
            end
            tick();
        end
        // stop in IDLE alone is ignored
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vectors++;
        if ({s0, s1, sel_valid, busy, frame_done} !== 5'b00000) begin
            miscompares++;
            $display("FAIL idle_stop got=%b exp=%b", {s0, s1, sel_valid, busy, frame_done}, 5'b00000);
        end
    endtask

    task automatic test_start_stop_together();
        logic [4:0] exp;
        stop = 1'b1;
        pulse_start(4'b0001, 4'd1);
        stop = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef SEQ_GAP_EN
            exp = {2'b00, (k % 2) == 0, 1'b1, (k % 2) == 1};
`else
            exp = {2'b00, 1'b1, 1'b1, k > 0};
`endif
            vectors++;
            if ({s0, s1, sel_valid, busy, frame_done} !== exp) begin
                miscompares++;
                $display("FAIL start_stop k=%0d got=%b exp=%b", k, {s0, s1, sel_valid, busy, frame_done}, exp);
            end
            tick();
        end
        do_reset();
    endtask

`ifdef SEQ_GAP_EN
    task automatic test_gap();
        logic [4:0] exp_tab [6];
        exp_tab = '{5'b00110, 5'b00010, 5'b01110, 5'b01011, 5'b00110, 5'b00010};
        pulse_start(4'b0011, 4'd1);
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if ({s0, s1, sel_valid, busy, frame_done} !== exp_tab[k]) begin
                miscompares++;
                $display("FAIL gap k=%0d got=%b exp=%b", k, {s0, s1, sel_valid, busy, frame_done}, exp_tab[k]);
            end
            tick();
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
`ifdef SEQ_GAP_EN
        test_gap();
`else
        test_all_ch();
        test_sparse();
        test_dwell_zero();
        test_stop();
        test_async_reset();
`endif
        test_empty_start();
        test_start_stop_together();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_sel_sequencer.md
Name: demux_sel_sequencer

Overview:
Round-robin select generator that sits directly upstream of the 1x4 demux decoder. It drives that decoder's s0/s1 select pair.
It steps through the enabled output channels and holds each selection for a programmable number of clocks (the dwell). It flags when the selection is valid and pulses once per completed frame.
Software or the top-level controller starts and stops it. The demux then turns s0/s1 into one-hot d0..d3.

Parameters:
DWELL_W, 4, width of dwell count input/counter
NUM_CH, 4, channel count; fixed at 4 (2-bit select); not overridable

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin sequencing
stop  input  1  one-cycle request to halt at end of current frame
ch_en  input  4  per-channel enable mask, bit i = channel i
dwell  input  DWELL_W  cycles per channel; 0 treated as 1
s0  output  1  select MSB (channel index bit 1)
s1  output  1  select LSB (channel index bit 0)
sel_valid  output  1  s0/s1 currently hold an active selection
busy  output  1  sequencer not in IDLE
frame_done  output  1  one-cycle pulse when the last enabled channel finishes its dwell

Behaviour:
- Encoding: channel index = {s0,s1}. Ch0=00, ch1=01, ch2=10, ch3=11. Matches the downstream decoder's d0..d3 mapping.
- Reset (async, rst=1): state=IDLE and all outputs 0. Counter, latched mask, latched dwell and stop_pend are cleared. A reset mid-dwell aborts immediately with no frame_done.
- States: IDLE, DWELL (plus GAP when SEQ_GAP_EN is defined).
- IDLE:
  - busy=0, sel_valid=0, s0=s1=0.
  - start=1 with ch_en!=0: latch ch_en into en_r. Latch dwell_r = (dwell==0 ? 1 : dwell). Select the lowest enabled channel. Go to DWELL.
  - start=1 with ch_en==0: ignored, stay in IDLE.
- Latency: start sampled at edge N gives sel_valid=1 with the first channel on s0/s1 from edge N onward, i.e. visible in cycle N+1.
- DWELL:
  - busy=1, sel_valid=1.
  - cnt counts 1..dwell_r, so the selection is held exactly dwell_r cycles.
  - On the final cycle, advance to the next enabled channel searching cyclically from current+1 (wrap 3→0).
- Frame boundary:
  - A frame ends when the channel just finished is the highest enabled bit in en_r.
  - frame_done=1 for the cycle after that dwell's final cycle, registered together with the channel change.
  - With only one enabled channel, the same channel is reselected and frame_done pulses every dwell_r cycles.
- Stop:
  - stop=1 while busy sets stop_pend.
  - At the frame boundary with stop_pend=1: frame_done still pulses, and the state goes to IDLE in the same edge. sel_valid=0 and s0=s1=0 from then on.
  - stop in IDLE is ignored.
- Start while busy: ignored. ch_en and dwell changes while busy are ignored; they take effect on the next start.
- Simultaneous start and stop in IDLE: start wins, stop ignored.
- Outputs s0, s1, sel_valid, busy and frame_done are all registered (glitch-free into the decoder).

Optional Feature:
SEQ_GAP_EN
- Defined: one GAP cycle is inserted between consecutive channel dwells, with sel_valid=0 and s0/s1 holding the outgoing channel (break-before-make). frame_done is asserted during the GAP cycle that follows the last channel. A single-channel configuration also gets a GAP each period.
- Undefined: no GAP state; channels change back-to-back as described above.

Decomposition:
- Package demux_seq_pkg:
  - state enum {IDLE, DWELL, GAP}
  - localparam NUM_CH=4
  - localparam SEL_W=2
  - function next_ch(cur, mask): cyclic search for the next set bit after cur
- Sub-module rr_next_ch: combinational 4-bit mask plus 2-bit current index in; next index and a wrap flag out. Shared by the DWELL→DWELL and GAP→DWELL paths.

Test Plan:
1. ch_en=1111, dwell=2, start pulse → s0s1 sequence 00,00,01,01,10,10,11,11,00...; frame_done pulses once per 8 cycles, in the cycle after the second 11.
2. ch_en=1010, dwell=3 → only 01 and 11, each held 3 cycles; frame_done every 6 cycles; s0s1 never 00 or 10 while sel_valid=1.
3. dwell=0, ch_en=0100 → s0s1=10 continuously; frame_done every cycle; busy=1.
4. stop mid-frame (ch_en=1111, dwell=2, stop during ch1) → sequence finishes ch2 and ch3; frame_done pulses; then busy=0, sel_valid=0, s0s1=00.
5. rst asserted asynchronously mid-dwell on ch2 → all outputs 0 immediately with no clock edge; no frame_done; a following start resumes from ch0.
6. start with ch_en=0000 → remains IDLE, busy=0. Under SEQ_GAP_EN with ch_en=0011, dwell=1 → sel_valid pattern 1,0,1,0; s0s1 00,00,01,01.
